// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - shared shot states, default constants and health bar encoding
package combat_pkg;

    typedef enum logic [1:0] {
        READY,
        FIRE,
        FLIGHT,
        COOLDOWN
    } shot_state_t;

    localparam int HEALTH_MAX_DEF = 5;
    localparam int COOLDOWN_DEF   = 30;
    localparam int FLIGHT_DEF     = 170;

    localparam int HEALTH_W = 3;
    localparam int CNT_W    = 8;
    localparam int BAR_MAX  = 7;

    // Thermometer code: segment i is lit while health is above i.
    function automatic logic [BAR_MAX-1:0] health_to_bar(input logic [HEALTH_W-1:0] health);
        logic [BAR_MAX-1:0] bar;
        for (int i = 0; i < BAR_MAX; i++) begin
            bar[i] = (health > HEALTH_W'(i));
        end
        return bar;
    endfunction

endpackage

// File: rtl/shooter_sequencer.sv
// rtl/shooter_sequencer.sv - one shooter's fire/flight/cooldown sequencer with request and hit edge detection
module shooter_sequencer
    import combat_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEF,
    parameter int FLIGHT_FRAMES   = FLIGHT_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    input  logic shoot_req,
    input  logic hit,
    output logic fire,
    output logic ready,
    output logic damage_pulse
);

    localparam logic [CNT_W-1:0] FLIGHT_LOAD   = CNT_W'(FLIGHT_FRAMES);
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_FRAMES);

    shot_state_t      state;
    shot_state_t      state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_next;
    logic             req_q;
    logic             shoot_edge;
    logic             hit_q;
    logic             hit_edge;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= READY;
            frame_cnt  <= '0;
            req_q      <= 1'b0;
            shoot_edge <= 1'b0;
            hit_q      <= 1'b0;
            hit_edge   <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            req_q      <= shoot_req;
            shoot_edge <= shoot_req & ~req_q;
            hit_q      <= hit;
            hit_edge   <= hit & ~hit_q;
        end
    end

    always_comb begin
        state_next     = state;
        frame_cnt_next = frame_cnt;
        fire           = 1'b0;
        damage_pulse   = 1'b0;

        case (state)
            READY: begin
                if (shoot_edge && enable) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                fire           = 1'b1;
                frame_cnt_next = FLIGHT_LOAD;
                state_next     = FLIGHT;
            end
            FLIGHT: begin
                // A hit landing on the same cycle as the last flight tick still counts.
                if (hit_edge) begin
                    damage_pulse   = 1'b1;
                    frame_cnt_next = COOLDOWN_LOAD;
                    state_next     = COOLDOWN;
                end else if (tick) begin
                    if (frame_cnt <= CNT_W'(1)) begin
                        frame_cnt_next = COOLDOWN_LOAD;
                        state_next     = COOLDOWN;
                    end else begin
                        frame_cnt_next = frame_cnt - CNT_W'(1);
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (frame_cnt <= CNT_W'(1)) begin
                        frame_cnt_next = '0;
                        state_next     = READY;
                    end else begin
                        frame_cnt_next = frame_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = READY;
            end
        endcase

        if (clear) begin
            state_next     = READY;
            frame_cnt_next = '0;
            fire           = 1'b0;
            damage_pulse   = 1'b0;
        end
    end

    assign ready = (state == READY);

endmodule

// File: rtl/combat_controller.sv
// rtl/combat_controller.sv - frame tick sync, shooter sequencing, health counters and dead flags for a fight
module combat_controller
    import combat_pkg::*;
#(
    parameter int HEALTH_MAX      = HEALTH_MAX_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEF,
    parameter int FLIGHT_FRAMES   = FLIGHT_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  start_l,
    input  logic                  battle_l,
    input  logic                  player_shoot_req,
    input  logic                  npc_shoot_req,
    input  logic                  npc_hit,
    input  logic                  player_hit,
    output logic                  player_fire,
    output logic                  npc_fire,
    output logic [HEALTH_W-1:0]   player_health,
    output logic [HEALTH_W-1:0]   npc_health,
    output logic [HEALTH_MAX-1:0] player_health_bar,
    output logic [HEALTH_MAX-1:0] npc_health_bar,
    output logic                  player_dead,
    output logic                  npc_dead,
    output logic                  player_ready,
    output logic                  npc_ready
);

    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(HEALTH_MAX);

    logic                frame_meta;
    logic                frame_sync;
    logic                frame_prev;
    logic                tick;
    logic                player_shot_lands;
    logic                npc_shot_lands;
    logic [HEALTH_W-1:0] player_health_next;
    logic [HEALTH_W-1:0] npc_health_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_meta <= 1'b0;
            frame_sync <= 1'b0;
            frame_prev <= 1'b0;
        end else begin
            frame_meta <= frame_clk;
            frame_sync <= frame_meta;
            frame_prev <= frame_sync;
        end
    end

    assign tick = frame_sync & ~frame_prev;

    // The player's shot targets the NPC hitbox, and vice versa.
    shooter_sequencer #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .FLIGHT_FRAMES   (FLIGHT_FRAMES)
    ) u_player_shooter (
        .Clk          (Clk),
        .Reset        (Reset),
        .tick         (tick),
        .clear        (start_l),
        .enable       (battle_l),
        .shoot_req    (player_shoot_req),
        .hit          (npc_hit),
        .fire         (player_fire),
        .ready        (player_ready),
        .damage_pulse (player_shot_lands)
    );

    shooter_sequencer #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .FLIGHT_FRAMES   (FLIGHT_FRAMES)
    ) u_npc_shooter (
        .Clk          (Clk),
        .Reset        (Reset),
        .tick         (tick),
        .clear        (start_l),
        .enable       (battle_l),
        .shoot_req    (npc_shoot_req),
        .hit          (player_hit),
        .fire         (npc_fire),
        .ready        (npc_ready),
        .damage_pulse (npc_shot_lands)
    );

    // Outside battle the counters hold, so shots retiring after win/lose deal no damage.
    always_comb begin
        player_health_next = player_health;
        npc_health_next    = npc_health;
        if (start_l) begin
            player_health_next = HEALTH_FULL;
            npc_health_next    = HEALTH_FULL;
        end else if (battle_l) begin
            if (npc_shot_lands && (player_health != '0)) begin
                player_health_next = player_health - HEALTH_W'(1);
            end
            if (player_shot_lands && (npc_health != '0)) begin
                npc_health_next = npc_health - HEALTH_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            player_health <= HEALTH_FULL;
            npc_health    <= HEALTH_FULL;
            player_dead   <= 1'b0;
            npc_dead      <= 1'b0;
        end else begin
            player_health <= player_health_next;
            npc_health    <= npc_health_next;
            player_dead   <= (player_health_next == '0);
            npc_dead      <= (npc_health_next == '0);
        end
    end

    assign player_health_bar = HEALTH_MAX'(health_to_bar(player_health));
    assign npc_health_bar    = HEALTH_MAX'(health_to_bar(npc_health));

endmodule
